// File: rtl/game_pkg.sv
// Shared types and helpers for the cat-and-dog game turn controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AIM,
    FLIGHT,
    RESOLVE,
    SWITCH,
    GAME_OVER
  } state_t;

  typedef logic       player_t;
  typedef logic [3:0] score_t;

  localparam player_t PLAYER_CAT = 1'b0;
  localparam player_t PLAYER_DOG = 1'b1;

  function automatic score_t sat_inc(score_t s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter; expired flags a zero count and the owner gates it by state.
module turn_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk60MHz,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk60MHz) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Game-turn controller: picks the active player and throw source, sequences aim/flight/resolve, keeps score.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int TURN_TIMEOUT_CYC   = 600_000_000,
  parameter int FLIGHT_TIMEOUT_CYC = 300_000_000,
  parameter int WIN_SCORE          = 3
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       start,
  input  logic       local_player,
  input  logic       btn_throw,
  input  logic       remote_throw,
  input  logic       proj_done,
  input  logic       hit,
  output logic       current_player,
  output logic       turn,
  output logic       throw_flag,
  output logic       left,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       game_over,
  output logic       winner
);

  localparam int MAX_CYC = (TURN_TIMEOUT_CYC > FLIGHT_TIMEOUT_CYC) ? TURN_TIMEOUT_CYC
                                                                    : FLIGHT_TIMEOUT_CYC;
  localparam int TIMER_W = $clog2(MAX_CYC);
  localparam logic [TIMER_W-1:0] TURN_LOAD   = TIMER_W'(TURN_TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] FLIGHT_LOAD = TIMER_W'(FLIGHT_TIMEOUT_CYC - 1);
  localparam score_t WIN = score_t'(WIN_SCORE);

  state_t  state_q, state_d;
  player_t player_q, player_d;
  logic    turn_d, throw_d, left_d, over_d, winner_d;
  logic    hit_q, hit_d;
  score_t  score0_d, score1_d, cur_score, new_score;
  logic    tmr_load, tmr_expired;
  logic [TIMER_W-1:0] tmr_value;

  turn_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .load     (tmr_load),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q    <= IDLE;
      player_q   <= PLAYER_CAT;
      turn       <= 1'b0;
      throw_flag <= 1'b0;
      left       <= 1'b0;
      score0     <= '0;
      score1     <= '0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      turn       <= turn_d;
      throw_flag <= throw_d;
      left       <= left_d;
      score0     <= score0_d;
      score1     <= score1_d;
      game_over  <= over_d;
      winner     <= winner_d;
      hit_q      <= hit_d;
    end
  end

  assign current_player = player_q;
  assign cur_score      = player_q ? score1 : score0;
  assign new_score      = hit_q ? sat_inc(cur_score) : cur_score;

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    turn_d    = turn;
    throw_d   = throw_flag;
    left_d    = left;
    score0_d  = score0;
    score1_d  = score1;
    over_d    = game_over;
    winner_d  = winner;
    hit_d     = hit_q;
    tmr_load  = 1'b0;
    tmr_value = TURN_LOAD;

    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_d  = AIM;
          player_d = PLAYER_CAT;
          left_d   = 1'b0;
          turn_d   = (local_player == PLAYER_CAT);
          score0_d = '0;
          score1_d = '0;
          over_d   = 1'b0;
          winner_d = 1'b0;
          tmr_load = 1'b1;
        end
      end
      AIM: begin
        // Only the source owning this turn may launch; a throw beats a same-cycle timeout.
        if (turn ? btn_throw : remote_throw) begin
          state_d   = FLIGHT;
          throw_d   = 1'b1;
          turn_d    = 1'b0;
          tmr_load  = 1'b1;
          tmr_value = FLIGHT_LOAD;
        end else if (tmr_expired) begin
          state_d = SWITCH;
          turn_d  = 1'b0;
        end
      end
      FLIGHT: begin
        if (proj_done) begin
          state_d = RESOLVE;
          throw_d = 1'b0;
          hit_d   = hit;
        end else if (tmr_expired) begin
          state_d = RESOLVE;
          throw_d = 1'b0;
          hit_d   = 1'b0;
        end
      end
      RESOLVE: begin
        if (player_q) score1_d = new_score;
        else          score0_d = new_score;
        if (new_score == WIN) begin
          state_d  = GAME_OVER;
          over_d   = 1'b1;
          winner_d = player_q;
        end else begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        state_d  = AIM;
        player_d = ~player_q;
        left_d   = ~player_q;
        turn_d   = (~player_q == local_player);
        tmr_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with short timeouts (turn 16, flight 32, win at 2).
module tb_turn_scheduler;
  import game_pkg::*;

  logic       clk60MHz = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, local_player = 1'b0, btn_throw = 1'b0, remote_throw = 1'b0;
  logic       proj_done = 1'b0, hit = 1'b0;
  logic       current_player, turn, throw_flag, left, game_over, winner;
  logic [3:0] score0, score1;
  int checks = 0;
  int errors = 0;

  turn_scheduler #(.TURN_TIMEOUT_CYC(16), .FLIGHT_TIMEOUT_CYC(32), .WIN_SCORE(2)) dut (
    .clk60MHz(clk60MHz), .rst(rst), .start(start), .local_player(local_player),
    .btn_throw(btn_throw), .remote_throw(remote_throw), .proj_done(proj_done), .hit(hit),
    .current_player(current_player), .turn(turn), .throw_flag(throw_flag), .left(left),
    .score0(score0), .score1(score1), .game_over(game_over), .winner(winner)
  );

  always #5 clk60MHz = ~clk60MHz;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk60MHz);
      #1;
    end
  endtask

  task automatic pulse_start();  start = 1'b1;        tick(); start = 1'b0;        endtask
  task automatic pulse_btn();    btn_throw = 1'b1;    tick(); btn_throw = 1'b0;    endtask
  task automatic pulse_remote(); remote_throw = 1'b1; tick(); remote_throw = 1'b0; endtask
  task automatic pulse_done(input logic h);
    proj_done = 1'b1; hit = h; tick(); proj_done = 1'b0; hit = 1'b0;
  endtask

  // Full throw from the given source: aim, short flight, landing, resolve, switch.
  task automatic do_throw(input logic from_local, input logic h);
    if (from_local) pulse_btn(); else pulse_remote();
    tick(2);
    pulse_done(h);
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
    checks++; if ({current_player, turn, throw_flag, left, score0, score1, game_over, winner} !== 14'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {current_player, turn, throw_flag, left, score0, score1, game_over, winner}); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_local_hit();
    local_player = 1'b0;
    pulse_start();
    checks++; if ({dut.state_q == AIM, current_player, turn} !== 3'b101) begin
      errors++; $display("FAIL start_aim got aim=%0b cp=%0b turn=%0b want 1 0 1", dut.state_q == AIM, current_player, turn); end
    tick(2);
    pulse_btn();
    checks++; if ({throw_flag, turn} !== 2'b10) begin
      errors++; $display("FAIL local_throw got flag=%0b turn=%0b want 1 0", throw_flag, turn); end
    tick(9);
    pulse_done(1'b1);
    checks++; if ({throw_flag, score0} !== 5'b0_0000) begin
      errors++; $display("FAIL resolve_entry got flag=%0b score0=%0d want 0 0", throw_flag, score0); end
    tick();
    checks++; if (score0 !== 4'd1) begin errors++; $display("FAIL score0_hit got %0d want 1", score0); end
    tick();
    checks++; if ({current_player, left, turn} !== 3'b110) begin
      errors++; $display("FAIL switch_to_dog got cp=%0b left=%0b turn=%0b want 1 1 0", current_player, left, turn); end
  endtask

  task automatic test_remote_source();
    pulse_btn(); tick(); pulse_btn();
    checks++; if ({throw_flag, dut.state_q == AIM} !== 2'b01) begin
      errors++; $display("FAIL btn_ignored got flag=%0b aim=%0b want 0 1", throw_flag, dut.state_q == AIM); end
    pulse_remote();
    checks++; if (throw_flag !== 1'b1) begin errors++; $display("FAIL remote_throw got %0b want 1", throw_flag); end
    tick(3);
    pulse_done(1'b0);
    tick(2);
    checks++; if ({current_player, turn, score0, score1} !== {2'b01, 4'd1, 4'd0}) begin
      errors++; $display("FAIL remote_miss got cp=%0b turn=%0b s0=%0d s1=%0d want 0 1 1 0", current_player, turn, score0, score1); end
  endtask

  task automatic test_turn_timeout();
    tick(15);
    checks++; if ({dut.state_q == AIM, current_player} !== 2'b10) begin
      errors++; $display("FAIL aim_before_expiry got aim=%0b cp=%0b want 1 0", dut.state_q == AIM, current_player); end
    tick();
    checks++; if (dut.state_q !== SWITCH) begin errors++; $display("FAIL expiry_switch got %0d want SWITCH", dut.state_q); end
    tick();
    checks++; if ({current_player, turn, left, score0, score1} !== {3'b101, 4'd1, 4'd0}) begin
      errors++; $display("FAIL forfeit_cat got cp=%0b turn=%0b left=%0b s0=%0d s1=%0d want 1 0 1 1 0", current_player, turn, left, score0, score1); end
    tick(17);
    checks++; if ({current_player, turn} !== 2'b01) begin
      errors++; $display("FAIL forfeit_dog got cp=%0b turn=%0b want 0 1", current_player, turn); end
  endtask

  task automatic test_flight_timeout();
    pulse_btn();
    tick(31);
    checks++; if ({throw_flag, dut.state_q == FLIGHT} !== 2'b11) begin
      errors++; $display("FAIL flight_before_expiry got flag=%0b flight=%0b want 1 1", throw_flag, dut.state_q == FLIGHT); end
    tick();
    checks++; if ({throw_flag, dut.state_q == RESOLVE} !== 2'b01) begin
      errors++; $display("FAIL flight_expiry got flag=%0b resolve=%0b want 0 1", throw_flag, dut.state_q == RESOLVE); end
    tick(2);
    checks++; if ({current_player, score0, score1} !== {1'b1, 4'd1, 4'd0}) begin
      errors++; $display("FAIL timeout_miss got cp=%0b s0=%0d s1=%0d want 1 1 0", current_player, score0, score1); end
    pulse_remote();
    tick(31);
    pulse_done(1'b1);
    tick();
    checks++; if ({score0, score1} !== {4'd1, 4'd1}) begin
      errors++; $display("FAIL done_beats_expiry got s0=%0d s1=%0d want 1 1", score0, score1); end
    tick();
    checks++; if (current_player !== 1'b0) begin errors++; $display("FAIL after_dog_hit cp got %0b want 0", current_player); end
  endtask

  task automatic test_game_over();
    pulse_btn(); tick(2); pulse_done(1'b1); tick();
    checks++; if ({game_over, winner, turn, throw_flag, score0} !== {4'b1000, 4'd2}) begin
      errors++; $display("FAIL cat_wins got over=%0b win=%0b turn=%0b flag=%0b s0=%0d want 1 0 0 0 2", game_over, winner, turn, throw_flag, score0); end
    pulse_btn(); tick();
    checks++; if ({dut.state_q == GAME_OVER, throw_flag, score0} !== {2'b10, 4'd2}) begin
      errors++; $display("FAIL over_ignores_btn got over_st=%0b flag=%0b s0=%0d want 1 0 2", dut.state_q == GAME_OVER, throw_flag, score0); end
    pulse_start();
    checks++; if ({dut.state_q == AIM, game_over, current_player, turn, score0, score1} !== {4'b1001, 8'd0}) begin
      errors++; $display("FAIL restart got aim=%0b over=%0b cp=%0b turn=%0b s0=%0d s1=%0d want 1 0 0 1 0 0", dut.state_q == AIM, game_over, current_player, turn, score0, score1); end
    do_throw(1'b1, 1'b0);
    do_throw(1'b0, 1'b1);
    do_throw(1'b1, 1'b0);
    do_throw(1'b0, 1'b1);
    checks++; if ({game_over, winner, current_player, score0, score1} !== {3'b111, 4'd0, 4'd2}) begin
      errors++; $display("FAIL dog_wins got over=%0b win=%0b cp=%0b s0=%0d s1=%0d want 1 1 1 0 2", game_over, winner, current_player, score0, score1); end
  endtask

  task automatic test_reset_in_flight();
    pulse_start();
    pulse_btn();
    tick(3);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({current_player, turn, throw_flag, left, score0, score1, game_over, winner} !== 14'h0) begin
      errors++; $display("FAIL midflight_reset got %h want 0", {current_player, turn, throw_flag, left, score0, score1, game_over, winner}); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL midflight_state got %0d want IDLE", dut.state_q); end
    pulse_done(1'b1); tick(2);
    checks++; if ({dut.state_q == IDLE, score0, score1, throw_flag} !== {1'b1, 9'd0}) begin
      errors++; $display("FAIL done_after_reset got idle=%0b s0=%0d s1=%0d flag=%0b want 1 0 0 0", dut.state_q == IDLE, score0, score1, throw_flag); end
  endtask

  initial begin
    test_reset();
    test_local_hit();
    test_remote_source();
    test_turn_timeout();
    test_flight_timeout();
    test_game_over();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Game-turn controller for the cat-and-dog throwing game.
- Decides which player (0 = cat, 1 = dog) is active and which source may trigger a throw: the local button or the remote board's throw pulse.
- Sequences each throw through aim, flight and resolve, and keeps the scores.
- Outputs current_player, turn, throw_flag and left to the projectile datapath and to the LED display logic.

Parameters:
- TURN_TIMEOUT_CYC, 600_000_000, cycles allowed in AIM before the turn is forfeited (10 s at 60 MHz).
- FLIGHT_TIMEOUT_CYC, 300_000_000, maximum cycles in FLIGHT before the throw is forced to resolve as a miss.
- WIN_SCORE, 3, hits needed to win; range 1..15.

Ports:
- clk60MHz  input  1  system clock, 60 MHz
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; starts or restarts a game
- local_player  input  1  player id owned by this board; static during a game
- btn_throw  input  1  one-cycle pulse; local throw request (already debounced)
- remote_throw  input  1  one-cycle pulse; throw request received from the remote board
- proj_done  input  1  one-cycle pulse; projectile has landed
- hit  input  1  qualified by proj_done; 1 = opponent was hit
- current_player  output  1  active player id
- turn  output  1  1 = the local board may throw now
- throw_flag  output  1  high while a projectile is in flight
- left  output  1  throw direction; 1 = leftwards (player 1 throws left)
- score0  output  4  hits scored by player 0
- score1  output  4  hits scored by player 1
- game_over  output  1  game finished
- winner  output  1  id of the winning player; valid while game_over is high

Behaviour:
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE. Reset mid-operation (including during FLIGHT) forces all of this on the next edge, so throw_flag drops one cycle after rst is sampled.
- IDLE: outputs hold their reset values. start → AIM with current_player=0, left=0, scores cleared, timer loaded.
- AIM:
  - turn = (current_player == local_player); it is registered on the same edge that enters AIM.
  - The accepted throw source is btn_throw when turn=1, otherwise remote_throw. A pulse from the other source is ignored.
  - Accepted throw sampled at edge N → at N+1 the state is FLIGHT, throw_flag=1, turn=0, and the timer is loaded with FLIGHT_TIMEOUT_CYC.
  - Timer expiry after TURN_TIMEOUT_CYC cycles in AIM → the turn is forfeited. State goes to SWITCH; no score change.
  - A throw and expiry in the same cycle → the throw wins.
- FLIGHT:
  - throw_flag=1.
  - proj_done at edge M → RESOLVE at M+1 with throw_flag=0; the hit value is latched at M.
  - Flight timer expiry → RESOLVE with latched hit=0.
  - proj_done and expiry in the same cycle → proj_done wins.
  - btn_throw, remote_throw and start are ignored.
- RESOLVE (exactly 1 cycle):
  - If the latched hit=1, the active player's score increments, saturating at 15.
  - If the new score equals WIN_SCORE → GAME_OVER with winner=current_player and game_over=1.
  - Otherwise → SWITCH.
- SWITCH (exactly 1 cycle): current_player toggles, left takes the new current_player, timer reloads to TURN_TIMEOUT_CYC, then → AIM.
- Latency: proj_done at M → score visible at M+2 → toggled player at M+3 → turn valid at M+3.
- GAME_OVER:
  - Scores, winner and current_player hold; turn=0, throw_flag=0.
  - start → clear scores, game_over=0, current_player=0, → AIM.
- start outside IDLE and GAME_OVER is ignored.
- proj_done outside FLIGHT is ignored.
- Timer: a single down-counter, width = $clog2 of the larger timeout parameter.
  - Loaded with value-1; expiry asserts when the count is 0 while the owning state is active.
  - The timer is free while in IDLE, RESOLVE, SWITCH and GAME_OVER.

Decomposition:
- The shared package game_pkg holds:
  - typedef enum for the states: IDLE, AIM, FLIGHT, RESOLVE, SWITCH, GAME_OVER.
  - typedef player_t (1 bit).
  - constants PLAYER_CAT=0 and PLAYER_DOG=1.
  - typedef score_t (logic [3:0]).
- Sub-module turn_timer: a loadable down-counter with load, value and expired ports, plus a WIDTH parameter. It is reused for both timeouts.

Test Plan:
- Bench parameters: TURN_TIMEOUT_CYC=16, FLIGHT_TIMEOUT_CYC=32, WIN_SCORE=2.
- Scenario 1: local_player=0, start, btn_throw 3 cycles later → throw_flag=1 the cycle after; proj_done with hit=1 at 10 cycles → score0=1 two cycles later, current_player=1, left=1, turn=0.
- Scenario 2: local_player=0, current_player=1, btn_throw pulses → ignored, state stays AIM. remote_throw → throw_flag=1 next cycle.
- Scenario 3: no throw for 16 cycles in AIM → current_player toggles, both scores unchanged, turn tracks the new player.
- Scenario 4: in FLIGHT with no proj_done → after 32 cycles RESOLVE as a miss; score unchanged; throw_flag drops. Then assert proj_done and the flight expiry in the same cycle with hit=1 → score increments.
- Scenario 5: player 0 lands two hits → game_over=1, winner=0, score0=2, turn=0. btn_throw is ignored. start → scores 0, game_over=0, AIM with current_player=0.
- Scenario 6: rst asserted mid-FLIGHT → the next cycle shows all outputs 0 and the state IDLE; proj_done arriving afterwards has no effect.
